// File: rtl/score_bcd_counter_if.sv
// score_bcd_counter_if: display data bus from the score source to the 7-segment stage.
//   o_data  32  [15:0] score, [31:16] high score (packed BCD)
//   o_cs     1  one-cycle capture strobe, high while o_data holds a new value
// Modports: master (score source drives), slave (display stage samples).
interface score_bcd_counter_if;
  logic [31:0] o_data;
  logic        o_cs;

  modport master (output o_data, output o_cs);
  modport slave  (input  o_data, input  o_cs);
endinterface

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: game score source for the 7-segment display path.
// Tracks IDLE/RUN/OVER, advances a 4-digit packed-BCD score once every TICK_DIV cycles
// while running (saturating at 9999), and optionally keeps a 4-digit high score.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset, clears all state
//   i_start    start/restart request (IDLE -> RUN, OVER -> RUN with score cleared)
//   i_collide  collision event (RUN -> OVER)
//   i_pause    level, freezes the prescaler while in RUN
//   o_state    registered state: 2'b00 IDLE, 2'b01 RUN, 2'b10 OVER
//   disp       display bus (master): o_data = {high score, score}, o_cs strobe
//
// Build option: define SCORE_HISCORE_EN to build the high-score register and compare;
// otherwise o_data[31:16] is constant zero.
module score_bcd_counter #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic                       i_collide,
  input  logic                       i_pause,
  output logic [1:0]                 o_state,
  score_bcd_counter_if.master        disp
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TickMax = PW'(TICK_DIV - 1);
  localparam logic [15:0] ScoreMax = 16'h9999;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StOver = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   hi_q, hi_d;
  logic          cs_q, cs_d;

`ifdef SCORE_HISCORE_EN
  logic over_first_q, over_first_d;
`endif

  // Ripple +1 across four BCD digits; the caller handles saturation at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    score_d = score_q;
    hi_d    = hi_q;
`ifdef SCORE_HISCORE_EN
    over_first_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        score_d = '0;
        presc_d = '0;
        if (i_start) state_d = StRun;
      end
      StRun: begin
        // Collision wins over a tick in the same cycle; pause never masks it.
        if (i_collide) begin
          state_d = StOver;
`ifdef SCORE_HISCORE_EN
          over_first_d = 1'b1;
`endif
        end else if (!i_pause) begin
          if (presc_q == TickMax) begin
            presc_d = '0;
            if (score_q != ScoreMax) score_d = bcd_inc(score_q);
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      StOver: begin
        if (i_start) begin
          state_d = StRun;
          score_d = '0;
          presc_d = '0;
        end
`ifdef SCORE_HISCORE_EN
        // Unsigned compare of packed BCD preserves decimal order.
        else if (over_first_q && (score_q > hi_q)) begin
          hi_d = score_q;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
    // Strobe exactly when the bus value changes this cycle.
    cs_d = ({hi_d, score_d} != {hi_q, score_q});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      score_q <= '0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      score_q <= score_d;
      cs_q    <= cs_d;
    end
  end

`ifdef SCORE_HISCORE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q         <= '0;
      over_first_q <= 1'b0;
    end else begin
      hi_q         <= hi_d;
      over_first_q <= over_first_d;
    end
  end
`else
  assign hi_q = '0;
`endif

  assign o_state     = state_q;
  assign disp.o_data = {hi_q, score_q};
  assign disp.o_cs   = cs_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
module tb_score_bcd_counter;

`ifdef SCORE_HISCORE_EN
  localparam bit HiEn = 1'b1;
`else
  localparam bit HiEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_start = 1'b0;
  logic       i_collide = 1'b0;
  logic       i_pause = 1'b0;
  logic [1:0] o_state;

  score_bcd_counter_if disp_if ();

  score_bcd_counter #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_collide (i_collide),
    .i_pause   (i_pause),
    .o_state   (o_state),
    .disp      (disp_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        start;
    logic        collide;
    logic        pause;
    logic [1:0]  st;
    logic [31:0] data;
    logic        cs;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_score(input logic [15:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (disp_if.o_data[15:0] !== target && n < budget) begin
      step();
      n++;
    end
    total++;
    if (disp_if.o_data[15:0] !== target) begin
      bad++;
      $display("FAIL %s: score %h after %0d cycles, want %h", name, disp_if.o_data[15:0],
               n, target);
    end
  endtask

  initial begin
    logic [15:0] h1, h12;
    int          pulses, misplaced;
    h1  = HiEn ? 16'h0001 : 16'h0000;
    h12 = HiEn ? 16'h0012 : 16'h0000;

    //          start collide pause  state  data              cs
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0000,     1'b0}; // start+collide in IDLE
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0000,     1'b0}; // presc 0->1
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0000,     1'b0}; // presc 1->2
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0000,     1'b0}; // paused
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0000,     1'b0}; // paused
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0000,     1'b0}; // presc 2->3
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0001,     1'b1}; // tick
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0001,     1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h0000_0001,     1'b0}; // pause can't mask collide
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b10, {h1, 16'h0001},    HiEn}; // high score load
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b10, {h1, 16'h0001},    1'b0}; // collide ignored in OVER
    vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b01, {h1, 16'h0000},    1'b1}; // restart clears score
    vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b01, {h1, 16'h0000},    1'b0}; // start ignored in RUN

    // Reset state
    step();
    check("reset data", disp_if.o_data, 32'h0);
    check("reset cs", {31'h0, disp_if.o_cs}, 32'h0);
    check("reset state", {30'h0, o_state}, 32'h0);
    step();
    reset = 1'b1;

    // Directed per-cycle vectors
    for (int i = 0; i < 13; i++) begin
      i_start   = vecs[i].start;
      i_collide = vecs[i].collide;
      i_pause   = vecs[i].pause;
      step();
      check($sformatf("vec%0d state", i), {30'h0, o_state}, {30'h0, vecs[i].st});
      check($sformatf("vec%0d data", i), disp_if.o_data, vecs[i].data);
      check($sformatf("vec%0d cs", i), {31'h0, disp_if.o_cs}, {31'h0, vecs[i].cs});
    end
    i_start = 1'b0; i_collide = 1'b0; i_pause = 1'b0;

    // 40 cycles of running: ten ticks spaced four cycles apart
    do_reset();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    pulses = 0;
    misplaced = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (disp_if.o_cs) begin
        pulses++;
        if (i % 4 != 0) misplaced++;
      end
    end
    check("run40 data", disp_if.o_data, 32'h0000_0010);
    check("run40 pulses", pulses, 10);
    check("run40 spacing", misplaced, 0);

    // Digit carry 0099 -> 0100
    wait_score(16'h0099, 400, "reach 0099");
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (disp_if.o_cs) pulses++;
    end
    check("carry data", {16'h0, disp_if.o_data[15:0]}, 32'h0000_0100);
    check("carry pulses", pulses, 1);

    // Saturation at 9999
    wait_score(16'h9999, 40500, "reach 9999");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (disp_if.o_cs) pulses++;
    end
    check("sat data", {16'h0, disp_if.o_data[15:0]}, 32'h0000_9999);
    check("sat pulses", pulses, 0);

    // Collision on a tick cycle at score 0012
    do_reset();
    check("rst hi clear", {16'h0, disp_if.o_data[31:16]}, 32'h0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_score(16'h0012, 100, "reach 0012");
    step(); step(); step();          // prescaler now at its last count
    i_collide = 1'b1;
    step();
    i_collide = 1'b0;
    check("coll state", {30'h0, o_state}, 32'h2);
    check("coll data", disp_if.o_data, 32'h0000_0012);
    check("coll cs", {31'h0, disp_if.o_cs}, 32'h0);
    step();
    check("hi data", disp_if.o_data, {h12, 16'h0012});
    check("hi cs", {31'h0, disp_if.o_cs}, {31'h0, HiEn});
    step();
    check("hi cs after", {31'h0, disp_if.o_cs}, 32'h0);

    // Restart from OVER, pause, lower score does not replace high score
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("restart state", {30'h0, o_state}, 32'h1);
    check("restart data", disp_if.o_data, {h12, 16'h0000});
    check("restart cs", {31'h0, disp_if.o_cs}, 32'h1);
    i_pause = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (disp_if.o_cs) pulses++;
    end
    i_pause = 1'b0;
    check("pause data", disp_if.o_data, {h12, 16'h0000});
    check("pause pulses", pulses, 0);
    wait_score(16'h0005, 40, "reach 0005");
    i_collide = 1'b1;
    step();
    i_collide = 1'b0;
    pulses = disp_if.o_cs ? 1 : 0;
    step();
    if (disp_if.o_cs) pulses++;
    check("low over data", disp_if.o_data, {h12, 16'h0005});
    check("low over state", {30'h0, o_state}, 32'h2);
    check("low over pulses", pulses, 0);

    // Asynchronous reset mid-RUN
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    #2;
    reset = 1'b0;
    #1;
    check("async data", disp_if.o_data, 32'h0);
    check("async cs", {31'h0, disp_if.o_cs}, 32'h0);
    check("async state", {30'h0, o_state}, 32'h0);
    step();
    reset = 1'b1;
    step();
    check("post reset data", disp_if.o_data, 32'h0);
    check("post reset state", {30'h0, o_state}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_bcd_counter.md
# score_bcd_counter

Game score source for the 7-segment display path. Tracks game state (idle / running / over), counts a 4-digit packed-BCD score at a fixed tick rate while running, and optionally keeps a 4-digit high score. It drives the display stage's 32-bit data bus and its capture strobe: `o_data` feeds `i_data`, and `o_cs` feeds `cs`.

## Interface
- `TICK_DIV`, default 5_000_000: clock cycles per score point while running; legal range ≥ 2. The prescaler width is `$clog2(TICK_DIV)`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state.
- `i_start`  in  1  start/restart request, sampled every cycle (single-cycle pulse expected).
- `i_collide`  in  1  collision event, sampled every cycle.
- `i_pause`  in  1  level; freezes score advance while high in RUN.
- `o_data`  out  32  registered; `[15:0]` = score (digit 0 at `[3:0]`), `[31:16]` = high score.
- `o_cs`  out  1  registered one-cycle strobe; high only in a cycle where `o_data` differs from its previous-cycle value.
- `o_state`  out  2  registered FSM state: 2'b00 IDLE, 2'b01 RUN, 2'b10 OVER.

## Operation
- Reset (`reset`=0) forces: `o_data`=32'h0, `o_cs`=0, `o_state`=IDLE, prescaler=0, high score=0.
- IDLE:
  - Score and prescaler are held at 0.
  - `i_start` → RUN. The score is already 0, so this transition gives no `o_cs`.
- RUN:
  - If `i_pause`=0, the prescaler increments each cycle.
  - When the prescaler equals `TICK_DIV-1`, it wraps to 0 and the score increments by one BCD count.
  - If `i_pause`=1, the prescaler holds.
  - `i_collide` → OVER. `i_start` is ignored in RUN.
- OVER:
  - Score and prescaler are frozen.
  - `i_start` → RUN, with score cleared to 0 and prescaler cleared to 0.
  - `i_collide` is ignored in OVER.
- BCD increment:
  - Each digit counts 0–9; 9 rolls to 0 with a carry into the next digit.
  - At 16'h9999 the score saturates: no further change and no `o_cs`.
- High score:
  - On the first cycle in OVER, if score > high score, high score is loaded with the score.
  - The comparison is a plain unsigned compare of the 16-bit packed BCD values, which preserves decimal order.
- Priority in the same cycle:
  - In RUN, `i_collide` beats a tick: the score does not increment on the collision cycle.
  - In OVER, `i_start` beats everything.
  - `i_pause` never masks `i_collide`.
- Reset asserted mid-RUN or mid-OVER immediately clears all outputs, including the high score.

## Timing
- Tick at cycle N (RUN, `i_pause`=0, prescaler=`TICK_DIV-1`, no collide) → new score on `o_data` and `o_cs`=1 at N+1.
- In an uninterrupted run, score updates are spaced exactly `TICK_DIV` cycles apart.
- The first tick comes `TICK_DIV` cycles after the cycle in which `i_start` is sampled.
- Collide at N → `o_state`=OVER at N+1. If the high score updates, `o_data[31:16]` changes and `o_cs`=1 at N+2.
- `i_start` in OVER at N → `o_state`=RUN and `o_data[15:0]`=0 at N+1. `o_cs`=1 at N+1 only if the score was nonzero.
- `o_cs` is never high for two consecutive cycles from one event. It is asserted in the same cycle as the new `o_data`, so the consumer captures both on the next edge.

## Configuration
- Macro `SCORE_HISCORE_EN`.
- Defined: the high-score register and compare logic are present, with behaviour as above.
- Undefined:
  - No high-score logic is built, and `o_data[31:16]` is constant 16'h0000.
  - Entering OVER never produces `o_cs`.
  - All other behaviour is identical.

## Test plan
All scenarios use `TICK_DIV`=4 and `SCORE_HISCORE_EN` defined unless stated otherwise.
- Release reset, pulse `i_start`, then run 40 cycles → `o_data`=32'h0000_0010; exactly 10 `o_cs` pulses, spaced 4 cycles apart.
- Run to score 16'h0099, then one more tick → `o_data[15:0]`=16'h0100 with a single `o_cs`; run further to 16'h9999, then 8 more cycles → value holds and no `o_cs`.
- At score 16'h0012, assert `i_collide` in the same cycle as a tick → score stays 16'h0012; `o_state`=OVER next cycle; `o_data`=32'h0012_0012 with `o_cs` one cycle later.
- Pulse `i_start` in OVER, hold `i_pause`=1 for 20 cycles (score stays 0, no `o_cs`), release, reach 16'h0005, then collide → `o_data`=32'h0012_0005, high score unchanged, no `o_cs` on OVER entry.
- Pulse `i_start` and `i_collide` together in IDLE → RUN entered, no OVER.
- With the macro undefined, repeat the collision scenario → `o_data[31:16]`=0 throughout.
- Drop `reset` asynchronously mid-RUN → `o_data`=0, `o_cs`=0, `o_state`=IDLE immediately; the high score is also cleared.
